fetch_bpu_unit: RTL and testbench
=================================

Name: fetch_bpu_unit

Overview:
- Parametrised successor to the pipeline Fetch stage: holds the PC and generates the next PC.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches/jumps redirect in Fetch instead of Decode.
- Sits between the Decode/Execute redirect logic and the instruction memory.
- Decode/Execute remain authoritative: they issue redirects and BTB updates.

Parameters:
- XLEN, 32: PC/target width in bits (≥ 8).
- BTB_ENTRIES, 16: BTB depth; power of two, 2..256. IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 0: PC value loaded on reset; bits [1:0] must be 00.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall_f  in  1  hold PC this cycle
- redirect_valid  in  1  force next PC to redirect_pc (misprediction/exception path)
- redirect_pc  in  XLEN  redirect address; bits [1:0] ignored, treated as 00
- update_valid  in  1  BTB training strobe from resolving stage
- update_pc  in  XLEN  PC of the resolved control instruction
- update_target  in  XLEN  resolved target address
- update_taken  in  1  resolved direction
- pc_f  out  XLEN  current fetch PC (registered)
- pc_plus4_f  out  XLEN  pc_f + 4, combinational, wraps modulo 2^XLEN
- pred_taken_f  out  1  BTB predicts taken for pc_f
- pred_target_f  out  XLEN  predicted next PC for pc_f

Behaviour:
- Reset (async, active-high, effective immediately, including mid-operation):
  - pc_f = RESET_PC.
  - All BTB valid bits = 0; all counters = 00; tags/targets are don't-care.
  - Outputs during reset: pc_plus4_f = RESET_PC+4, pred_taken_f = 0, pred_target_f = RESET_PC+4.
- Indexing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
  - Lookups use pc_f; updates use update_pc.
- Lookup (combinational, same cycle as pc_f):
  - hit = valid[idx] & (tag[idx] == tag(pc_f)).
  - pred_taken_f = hit & ctr[idx][1].
  - pred_target_f = pred_taken_f ? target[idx] : pc_plus4_f.
- Next-PC priority at each rising edge, highest first:
  1. redirect_valid: pc_f <= {redirect_pc[XLEN-1:2],2'b00}. Overrides stall_f.
  2. stall_f: pc_f holds.
  3. Otherwise: pc_f <= pred_target_f.
- Target low bits: target[1:0] is stored as 00; pred_target_f[1:0] is always 00.
- Update (registered, one edge, independent of stall_f and redirect_valid):
  - Entry hit (valid and tag match):
    - update_taken=1: ctr saturating increment (max 11); target <= update_target.
    - update_taken=0: ctr saturating decrement (min 00); target unchanged.
  - Entry miss:
    - update_taken=1: allocate/overwrite: valid=1, tag written, target written, ctr=10 (weakly taken).
    - update_taken=0: no change. Not-taken branches are never allocated.
- Read-during-update: when lookup and update hit the same entry in the same cycle, the lookup sees pre-update contents. The new state is visible from the next cycle.
- Aliasing: an allocation replaces any existing entry at that index regardless of its counter.
- Latency:
  - Prediction: 0 cycles (same cycle as pc_f).
  - Redirect: 1 edge.
  - Training: effective on the lookup after the update edge.
- PC wrap-around: pc_f + 4 wraps modulo 2^XLEN with no flag.
- Counter state encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: reset=1 mid-cycle with pc_f=0x40, then release; no stall, no redirect for 4 edges.
  - Required: pc_f=0 immediately on reset; then 0x4, 0x8, 0xC, 0x10; pred_taken_f=0 throughout.
- Allocation and prediction:
  - Stimulus: update_valid=1, update_pc=0x10, update_target=0x80, update_taken=1. Later pc_f reaches 0x10.
  - Required: pred_taken_f=1, pred_target_f=0x80; next pc_f=0x80.
- Counter saturation/hysteresis:
  - Stimulus: two not-taken updates on the 0x10 entry (ctr 10→01→00).
  - Required: pred_taken_f=0 at pc_f=0x10.
  - Stimulus: one taken update (ctr→01).
  - Required: still not taken.
  - Stimulus: three further taken updates.
  - Required: ctr saturates at 11.
  - Stimulus: one not-taken update.
  - Required: ctr=10, still taken.
- Priority:
  - Stimulus: stall_f=1 and redirect_valid=1 with redirect_pc=0x203, while pc_f=0x10 predicts 0x80.
  - Required: pc_f=0x200 next edge.
  - Stimulus: stall_f=1 alone.
  - Required: pc_f holds for 3 edges.
- Aliasing/tag mismatch (BTB_ENTRIES=16):
  - Stimulus: entry at 0x10 allocated; pc_f=0x50 (same idx=4, different tag).
  - Required: pred_taken_f=0.
  - Stimulus: taken update for 0x50→0x100.
  - Required: 0x50 now predicts 0x100; 0x10 no longer hits.
- Same-cycle read/update:
  - Stimulus: pc_f=0x20 (miss) while update allocates 0x20→0x300.
  - Required: that cycle pred_taken_f=0 and next pc=0x24; a later fetch of 0x20 predicts 0x300.

Source files
------------

// File: rtl/fetch_bpu_unit.sv
// Fetch-stage PC register with a direct-mapped branch target buffer.
// Each BTB entry holds a 2-bit counter, so taken control flow is predicted without waiting for Decode.
module fetch_bpu_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pc_plus4_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam int unsigned TGT_W = XLEN - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TGT_W-1:0]       target_q [BTB_ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;

  // Word-offset bits of these addresses carry no information.
  logic unused_low_bits;
  assign unused_low_bits = ^{redirect_pc[1:0], update_pc[1:0], update_target[1:0]};

  assign l_idx = pc_f[IDX_W+1:2];
  assign l_tag = pc_f[XLEN-1:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[XLEN-1:IDX_W+2];

  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Zero-latency lookup on the current fetch PC.
  assign pc_plus4_f    = pc_f + XLEN'(4);
  assign pred_taken_f  = l_hit && ctr_q[l_idx][1];
  assign pred_target_f = pred_taken_f ? {target_q[l_idx], 2'b00} : pc_plus4_f;

  // Next PC: redirect beats stall beats prediction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else if (redirect_valid) begin
      pc_f <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (!stall_f) begin
      pc_f <= pred_target_f;
    end
  end

  // Valid bits and saturating counters; allocation only on taken misses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        ctr_q[i] <= 2'b00;
      end
    end else if (update_valid) begin
      if (u_hit) begin
        if (update_taken && (ctr_q[u_idx] != 2'b11)) begin
          ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
        end else if (!update_taken && (ctr_q[u_idx] != 2'b00)) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (update_taken) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target payload needs no reset; a taken update either allocates or refreshes.
  always_ff @(posedge clk) begin
    if (update_valid && update_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= update_target[XLEN-1:2];
    end
  end

endmodule

// File: tb/tb_fetch_bpu_unit.sv
// Directed bench for fetch_bpu_unit: sequential fetch, BTB training, priority, aliasing, wrap.
module tb_fetch_bpu_unit;

  logic        clk;
  logic        reset;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;

  int errors = 0;
  int checks = 0;

  fetch_bpu_unit #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall_f(stall_f),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] a, input logic stall_after);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
    stall_f        = stall_after;
  endtask

  task automatic train(input logic [31:0] p, input logic [31:0] t, input logic tk);
    update_valid  = 1'b1;
    update_pc     = p;
    update_target = t;
    update_taken  = tk;
    tick();
    update_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (16) tick();
    checks++; if (pc_f !== 32'h40) begin errors++; $display("FAIL reset_pre pc_f=%h exp=%h", pc_f, 32'h40); end
    #2 reset = 1'b1;
    #1;
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL reset_async pc_f=%h exp=0", pc_f); end
    checks++; if (pc_plus4_f !== 32'h4) begin errors++; $display("FAIL reset_pc4 got=%h exp=4", pc_plus4_f); end
    checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset_pred got=%b exp=0", pred_taken_f); end
    checks++; if (pred_target_f !== 32'h4) begin errors++; $display("FAIL reset_tgt got=%h exp=4", pred_target_f); end
    tick();
    reset = 1'b0;
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL reset_hold pc_f=%h exp=0", pc_f); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc_f !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc_f, 32'(4 * i)); end
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL seq_pred[%0d] got=%b exp=0", i, pred_taken_f); end
    end
  endtask

  task automatic test_alloc();
    stall_f = 1'b1;
    update_valid = 1'b1; update_pc = 32'h10; update_target = 32'h80; update_taken = 1'b1;
    #1;
    checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL alloc_pre got=%b exp=0", pred_taken_f); end
    tick();
    update_valid = 1'b0;
    checks++; if (pc_f !== 32'h10) begin errors++; $display("FAIL alloc_stall pc_f=%h exp=10", pc_f); end
    checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL alloc_pred got=%b exp=1", pred_taken_f); end
    checks++; if (pred_target_f !== 32'h80) begin errors++; $display("FAIL alloc_tgt got=%h exp=80", pred_target_f); end
    stall_f = 1'b0;
    tick();
    checks++; if (pc_f !== 32'h80) begin errors++; $display("FAIL alloc_next pc_f=%h exp=80", pc_f); end
  endtask

  task automatic test_counter();
    goto_pc(32'h10, 1'b1);
    // 10 -> 01 -> 00 -> 00
    for (int i = 0; i < 3; i++) begin
      train(32'h10, 32'h80, 1'b0);
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL ctr_dec[%0d] got=%b exp=0", i, pred_taken_f); end
    end
    train(32'h10, 32'h80, 1'b1);  // 00 -> 01
    checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL ctr_hyst got=%b exp=0", pred_taken_f); end
    train(32'h10, 32'h80, 1'b1);  // 01 -> 10
    checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL ctr_weak got=%b exp=1", pred_taken_f); end
    train(32'h10, 32'h80, 1'b1);  // 10 -> 11
    train(32'h10, 32'h80, 1'b1);  // 11 saturates
    train(32'h10, 32'h80, 1'b0);  // 11 -> 10
    checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL ctr_sat got=%b exp=1", pred_taken_f); end
    checks++; if (pred_target_f !== 32'h80) begin errors++; $display("FAIL ctr_sat_tgt got=%h exp=80", pred_target_f); end
    checks++; if (pc_f !== 32'h10) begin errors++; $display("FAIL ctr_stall pc_f=%h exp=10", pc_f); end
  endtask

  task automatic test_priority();
    stall_f = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc_f !== 32'h200) begin errors++; $display("FAIL prio_redirect pc_f=%h exp=200", pc_f); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_f !== 32'h200) begin errors++; $display("FAIL prio_stall[%0d] pc_f=%h exp=200", i, pc_f); end
    end
  endtask

  task automatic test_alias();
    goto_pc(32'h50, 1'b1);
    checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL alias_miss got=%b exp=0", pred_taken_f); end
    checks++; if (pred_target_f !== 32'h54) begin errors++; $display("FAIL alias_miss_tgt got=%h exp=54", pred_target_f); end
    train(32'h50, 32'h100, 1'b1);
    checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL alias_new got=%b exp=1", pred_taken_f); end
    checks++; if (pred_target_f !== 32'h100) begin errors++; $display("FAIL alias_new_tgt got=%h exp=100", pred_target_f); end
    goto_pc(32'h10, 1'b1);
    checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL alias_evict got=%b exp=0", pred_taken_f); end
    checks++; if (pred_target_f !== 32'h14) begin errors++; $display("FAIL alias_evict_tgt got=%h exp=14", pred_target_f); end
  endtask

  task automatic test_same_cycle();
    goto_pc(32'h20, 1'b0);
    update_valid = 1'b1; update_pc = 32'h20; update_target = 32'h303; update_taken = 1'b1;
    #1;
    checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL rdw_pred got=%b exp=0", pred_taken_f); end
    tick();
    update_valid = 1'b0;
    checks++; if (pc_f !== 32'h24) begin errors++; $display("FAIL rdw_next pc_f=%h exp=24", pc_f); end
    goto_pc(32'h20, 1'b0);
    checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL rdw_later got=%b exp=1", pred_taken_f); end
    checks++; if (pred_target_f !== 32'h300) begin errors++; $display("FAIL rdw_later_tgt got=%h exp=300", pred_target_f); end
    tick();
    checks++; if (pc_f !== 32'h300) begin errors++; $display("FAIL rdw_follow pc_f=%h exp=300", pc_f); end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC, 1'b0);
    checks++; if (pc_plus4_f !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=0", pc_plus4_f); end
    tick();
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL wrap_pc pc_f=%h exp=0", pc_f); end
  endtask

  initial begin
    reset = 1'b1; stall_f = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
    test_reset();
    test_alloc();
    test_counter();
    test_priority();
    test_alias();
    test_same_cycle();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
